x_bus: RTL and testbench
========================

# x_bus

Horizontal multicast bus for one row of the PE array. Broadcasts a tagged value stream (ifmap data) to `PE_NUMS` PE wrappers and delivers each value only to the PEs whose scan-loaded ID matches the tag. Per-PE IDs are loaded through a serial ID scan chain before operation. The upstream global buffer drives it, and each PE wrapper's ifmap input port sinks it.

## Interface
- `PE_NUMS`, 14: number of PE target ports.
- `ID_LEN`, 4: width of a PE ID and of the tag field.
- `VALUE_LEN`, 8: width of the data value.
- `PSUM_WIDTH`, 32: accepted for uniform array parameterization; has no function in this block.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `enable`  in  1  upstream valid: `tag_value` holds a transfer request.
- `ready`  out  1  bus can accept the current request.
- `tag_value`  in  `ID_LEN+VALUE_LEN`  `{tag[ID_LEN-1:0], value[VALUE_LEN-1:0]}`; tag is the MSB field.
- `set_id`  in  1  ID scan shift enable.
- `id_scan_in`  in  `ID_LEN`  serial ID scan input.
- `id_scan_out`  out  `ID_LEN`  serial ID scan output, used for chaining buses.
- `pe_ready`  in  `PE_NUMS`  bit i is high when PE i can accept data.
- `pe_data`  out  `PE_NUMS*(VALUE_LEN+1)`  slice i is `{valid_i, value}` for PE i, at bits `[i*(VALUE_LEN+1) +: VALUE_LEN+1]`.

## Operation
- ID registers `id[0..PE_NUMS-1]` are `ID_LEN` bits each. ID all-ones (`{ID_LEN{1'b1}}`) means disabled and never matches any tag.
- Scan shift, active in any cycle with `set_id=1`:
  - `id[PE_NUMS-1] <= id_scan_in`
  - `id[k] <= id[k+1]` for k < PE_NUMS-1
  - `id_scan_out = id[0]` (combinational from the register).
  - After `PE_NUMS` shifts, the first value shifted in sits in `id[0]`.
- Match: `match_i = (id[i] == tag) && (id[i] != all-ones)`.
- `ready = !set_id && AND over i of (!match_i || pe_ready[i])`. Combinational.
  - If no PE matches, `ready=1` and the transfer is accepted and dropped.
- A transfer occurs in a cycle with `enable && ready`.
  - Next edge: for every i, `pe_data[i] <= {match_i, value}`.
  - Otherwise the valid bits clear to 0 and the value fields hold their last value.
- While `set_id=1`, no transfer occurs regardless of `enable`, and the valid bits clear.
- Multicast: several PEs sharing an ID all receive the same value in the same cycle.

## Timing
- Reset (`rst=0`, asynchronous) sets:
  - all `id[i]` to all-ones, so `id_scan_out` = all-ones;
  - all `pe_data` to 0 (valid and value);
  - `ready` then follows its combinational rule; with `set_id=0` it is 1.
- Latency: a transfer accepted at edge N shows `valid_i=1` on `pe_data` after edge N.
  - The valid pulse lasts one cycle per transfer.
  - Back-to-back transfers every cycle are supported.
- Scan: each `set_id` edge shifts one position. `id_scan_out` changes after the edge.
- `set_id` and `enable` high together: the scan takes priority and `ready=0`.
- Reset mid-transfer: pending output is lost, IDs return to disabled, and the scan must be reloaded.
- A matched PE with `pe_ready=0` blocks the whole transfer (`ready=0`). No partial delivery.

## Test plan
- Reset, then check outputs: `ready=1` (set_id=0), every `pe_data=0`, `id_scan_out=4'hF`; `enable=1` with any tag produces no valid bits.
- ID scan, `PE_NUMS=14`: shift 6,5,4,3,2,1,0,6,5,4,3,2,1,0. Required result: `id[0]=6, id[6]=0, id[7]=6, id[13]=0`. `id_scan_out` reads 6 after the 14th shift.
- Multicast with all `pe_ready=1`: send tags 0..6 with values `8'h00..8'h06` on consecutive cycles, then tags 0..6 with `8'hFF..8'hF9`.
  - Tag 0 gives `{1,8'h00}` on PEs 6 and 13 only, one cycle later.
  - Tag 6 gives the value on PEs 0 and 7.
  - All other valid bits stay 0.
- Backpressure: drop `pe_ready[13]` and send tag 0. Required: `ready=0` and no valid on PE 6 or PE 13. Raise `pe_ready[13]`: transfer completes.
- Scan/enable collision: hold `set_id=1` and `enable=1` together. Required: `ready=0` and no `pe_data` valid.
- Asynchronous reset asserted mid-stream clears `pe_data` immediately and returns IDs to `4'hF`.

Source files
------------

// File: rtl/x_bus.sv
// Horizontal multicast bus for one PE-array row: delivers a tagged value to every PE
// whose scan-loaded ID matches the tag, blocking the whole transfer if any target is busy.
module x_bus #(
  parameter int PE_NUMS    = 14,
  parameter int ID_LEN     = 4,
  parameter int VALUE_LEN  = 8,
  parameter int PSUM_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  output logic                               ready,
  input  logic [ID_LEN+VALUE_LEN-1:0]        tag_value,
  input  logic                               set_id,
  input  logic [ID_LEN-1:0]                  id_scan_in,
  output logic [ID_LEN-1:0]                  id_scan_out,
  input  logic [PE_NUMS-1:0]                 pe_ready,
  output logic [PE_NUMS*(VALUE_LEN+1)-1:0]   pe_data
);

  localparam int                SLICE_W = VALUE_LEN + 1;
  localparam logic [ID_LEN-1:0] ID_OFF  = '1;

  logic [ID_LEN-1:0]    id_q [PE_NUMS];
  logic [ID_LEN-1:0]    id_d [PE_NUMS];
  logic [PE_NUMS-1:0]   valid_q, valid_d;
  logic [VALUE_LEN-1:0] value_q, value_d;
  logic [PE_NUMS-1:0]   match;
  logic [ID_LEN-1:0]    tag;
  logic [VALUE_LEN-1:0] value;
  logic                 transfer;

  assign tag   = tag_value[ID_LEN+VALUE_LEN-1 -: ID_LEN];
  assign value = tag_value[VALUE_LEN-1:0];

  // All-ones ID marks a disabled PE so an unloaded row never captures data.
  always_comb begin
    match = '0;
    for (int i = 0; i < PE_NUMS; i++) begin
      match[i] = (id_q[i] == tag) && (id_q[i] != ID_OFF);
    end
  end

  assign ready       = !set_id && ((match & ~pe_ready) == '0);
  assign transfer    = enable && ready;
  assign id_scan_out = id_q[0];

  always_comb begin
    id_d    = id_q;
    valid_d = '0;
    value_d = value_q;
    if (set_id) begin
      for (int k = 0; k < PE_NUMS - 1; k++) begin
        id_d[k] = id_q[k+1];
      end
      id_d[PE_NUMS-1] = id_scan_in;
    end
    if (transfer) begin
      valid_d = match;
      value_d = value;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PE_NUMS; i++) begin
        id_q[i] <= ID_OFF;
      end
      valid_q <= '0;
      value_q <= '0;
    end else begin
      id_q    <= id_d;
      valid_q <= valid_d;
      value_q <= value_d;
    end
  end

  // Every PE sees the same value; only the valid bit differs per slice.
  for (genvar g = 0; g < PE_NUMS; g++) begin : g_slice
    assign pe_data[g*SLICE_W +: SLICE_W] = {valid_q[g], value_q};
  end

endmodule

// File: tb/tb_x_bus.sv
// Scoreboard bench for x_bus: stimulus pushes expected pe_data vectors,
// a negedge monitor pops and compares whenever the bus presents valid data.
module tb_x_bus;

  localparam int PE_NUMS   = 14;
  localparam int ID_LEN    = 4;
  localparam int VALUE_LEN = 8;
  localparam int SLICE_W   = VALUE_LEN + 1;
  localparam int PD_W      = PE_NUMS * SLICE_W;

  typedef struct {
    int              due;
    logic [PD_W-1:0] vec;
  } exp_t;

  logic                        clk;
  logic                        rst;
  logic                        enable;
  logic                        ready;
  logic [ID_LEN+VALUE_LEN-1:0] tag_value;
  logic                        set_id;
  logic [ID_LEN-1:0]           id_scan_in;
  logic [ID_LEN-1:0]           id_scan_out;
  logic [PE_NUMS-1:0]          pe_ready;
  logic [PD_W-1:0]             pe_data;

  exp_t exp_q[$];
  int   cyc = 0;
  int   total_checks = 0;
  int   passed_checks = 0;

  x_bus #(
    .PE_NUMS(PE_NUMS), .ID_LEN(ID_LEN), .VALUE_LEN(VALUE_LEN), .PSUM_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ready(ready), .tag_value(tag_value),
    .set_id(set_id), .id_scan_in(id_scan_in), .id_scan_out(id_scan_out),
    .pe_ready(pe_ready), .pe_data(pe_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PD_W-1:0] build_vec(input logic [PE_NUMS-1:0] mask,
                                                 input logic [VALUE_LEN-1:0] val);
    logic [PD_W-1:0] v;
    v = '0;
    for (int i = 0; i < PE_NUMS; i++) v[i*SLICE_W +: SLICE_W] = {mask[i], val};
    return v;
  endfunction

  function automatic logic [PE_NUMS-1:0] valid_bits(input logic [PD_W-1:0] v);
    logic [PE_NUMS-1:0] m;
    for (int i = 0; i < PE_NUMS; i++) m[i] = v[i*SLICE_W + VALUE_LEN];
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    total_checks++;
    if (actual === expected) passed_checks++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Drives one cycle of inputs; the transfer (if any) happens at the next rising edge.
  task automatic applyStimulus(input logic en, input logic [ID_LEN-1:0] tag,
                               input logic [VALUE_LEN-1:0] val, input logic sid,
                               input logic [ID_LEN-1:0] scan, input logic [PE_NUMS-1:0] prdy,
                               input logic [PE_NUMS-1:0] mask);
    logic exp_ready;
    @(posedge clk);
    #1;
    enable     = en;
    tag_value  = {tag, val};
    set_id     = sid;
    id_scan_in = scan;
    pe_ready   = prdy;
    #1;
    exp_ready = !sid && ((mask & ~prdy) == '0);
    checkOutput("ready", {127'd0, ready}, {127'd0, exp_ready});
    if (en && exp_ready && mask != '0) exp_q.push_back('{due: cyc + 1, vec: build_vec(mask, val)});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        checkOutput("missed_output", '0, e.vec);
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        checkOutput("pe_data", pe_data, e.vec);
      end else if (valid_bits(pe_data) != '0) begin
        checkOutput("unexpected_valid", {114'd0, valid_bits(pe_data)}, '0);
      end
    end
  end

  logic [ID_LEN-1:0]  scan_seq [PE_NUMS] = '{4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0,
                                             4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
  logic [PE_NUMS-1:0] tag_mask [7] = '{14'h2040, 14'h1020, 14'h0810, 14'h0408,
                                       14'h0204, 14'h0102, 14'h0081};
  localparam logic [PE_NUMS-1:0] ALL_RDY = '1;

  initial begin
    rst = 1'b0; enable = 1'b0; tag_value = '0; set_id = 1'b0; id_scan_in = '0;
    pe_ready = ALL_RDY;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("reset_ready", {127'd0, ready}, 128'd1);
    checkOutput("reset_pe_data", pe_data, '0);
    checkOutput("reset_scan_out", {124'd0, id_scan_out}, 128'hF);

    // With every ID disabled, requests are accepted and dropped.
    applyStimulus(1'b1, 4'd3, 8'h33, 1'b0, 4'd0, ALL_RDY, '0);
    applyStimulus(1'b1, 4'd15, 8'h44, 1'b0, 4'd0, ALL_RDY, '0);

    for (int k = 0; k < PE_NUMS; k++)
      applyStimulus(1'b0, 4'd0, 8'h00, 1'b1, scan_seq[k], ALL_RDY, '0);
    checkOutput("scan_out_13_shifts", {124'd0, id_scan_out}, 128'hF);
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, ALL_RDY, '0);
    checkOutput("scan_out_14_shifts", {124'd0, id_scan_out}, 128'h6);

    for (int t = 0; t < 7; t++)
      applyStimulus(1'b1, 4'(t), 8'(t), 1'b0, 4'd0, ALL_RDY, tag_mask[t]);
    for (int t = 0; t < 7; t++)
      applyStimulus(1'b1, 4'(t), 8'(8'hFF - t), 1'b0, 4'd0, ALL_RDY, tag_mask[t]);
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, ALL_RDY, '0);

    // PE 13 busy blocks the whole multicast to PEs 6 and 13.
    applyStimulus(1'b1, 4'd0, 8'h55, 1'b0, 4'd0, 14'h1FFF, tag_mask[0]);
    applyStimulus(1'b1, 4'd0, 8'h55, 1'b0, 4'd0, 14'h1FFF, tag_mask[0]);
    applyStimulus(1'b1, 4'd0, 8'h55, 1'b0, 4'd0, ALL_RDY, tag_mask[0]);
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, ALL_RDY, '0);

    // Scan wins over enable; this shifts a 0 in, so IDs become 5,4,3,2,1,0,6,5,4,3,2,1,0,0.
    applyStimulus(1'b1, 4'd0, 8'h77, 1'b1, 4'd0, ALL_RDY, tag_mask[0]);
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, ALL_RDY, '0);
    checkOutput("scan_out_after_collision", {124'd0, id_scan_out}, 128'h5);
    applyStimulus(1'b1, 4'd0, 8'hA5, 1'b0, 4'd0, ALL_RDY, 14'h3020);

    applyStimulus(1'b1, 4'd0, 8'h5A, 1'b0, 4'd0, ALL_RDY, 14'h3020);
    @(posedge clk);
    #2;
    checkOutput("pe_data_before_reset", pe_data, build_vec(14'h3020, 8'h5A));
    exp_q.delete();
    rst = 1'b0;
    #1;
    checkOutput("async_reset_pe_data", pe_data, '0);
    checkOutput("async_reset_scan_out", {124'd0, id_scan_out}, 128'hF);
    enable = 1'b0;
    #1 rst = 1'b1;

    applyStimulus(1'b1, 4'd0, 8'h11, 1'b0, 4'd0, ALL_RDY, '0);
    applyStimulus(1'b1, 4'd5, 8'h22, 1'b0, 4'd0, ALL_RDY, '0);
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, ALL_RDY, '0);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("scoreboard_drained", 128'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
